// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: ALU (A) and memory-load (M) requesters share the register file write port.
// Optional WB_BUSY_VEC_EN adds a per-register pending-write vector on Busy.
module reg_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              A_Valid,
  input  logic [ADDR_W-1:0] A_Reg,
  input  logic [DATA_W-1:0] A_Data,
  output logic              A_Ready,
  input  logic              M_Valid,
  input  logic [ADDR_W-1:0] M_Reg,
  input  logic [DATA_W-1:0] M_Data,
  output logic              M_Ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] Write_Reg,
  output logic [DATA_W-1:0] Write_Bus,
  output logic [15:0]       Busy
);

  logic              a_full, m_full;
  logic [ADDR_W-1:0] a_reg_q, m_reg_q;
  logic [DATA_W-1:0] a_data_q, m_data_q;
  logic              m_older;  // M holds the older entry when both are full
  logic              tie;      // both entries were loaded on the same edge
  logic              rr_m;     // round-robin pointer: 0 = A, 1 = M
  logic              a_grant, m_grant;
  logic              a_load, m_load;

  always_comb begin
    a_grant = 1'b0;
    m_grant = 1'b0;
    if (a_full && m_full) begin
      if (tie) begin
        a_grant = !rr_m;
        m_grant = rr_m;
      end else begin
        a_grant = !m_older;
        m_grant = m_older;
      end
    end else begin
      a_grant = a_full;
      m_grant = m_full;
    end
  end

  // Ready depends on buffer state only, so a draining buffer can refill in the same cycle.
  assign A_Ready = !a_full || a_grant;
  assign M_Ready = !m_full || m_grant;
  assign a_load  = A_Valid && A_Ready;
  assign m_load  = M_Valid && M_Ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_full    <= 1'b0;
      m_full    <= 1'b0;
      a_reg_q   <= '0;
      m_reg_q   <= '0;
      a_data_q  <= '0;
      m_data_q  <= '0;
      m_older   <= 1'b0;
      tie       <= 1'b0;
      rr_m      <= 1'b0;
      RegWrite  <= 1'b0;
      Write_Reg <= '0;
      Write_Bus <= '0;
    end else begin
      a_full <= a_load || (a_full && !a_grant);
      m_full <= m_load || (m_full && !m_grant);
      if (a_load) begin
        a_reg_q  <= A_Reg;
        a_data_q <= A_Data;
      end
      if (m_load) begin
        m_reg_q  <= M_Reg;
        m_data_q <= M_Data;
      end
      // A lone load is always the younger entry; the surviving one (if any) is older.
      if (a_load && m_load) begin
        tie <= 1'b1;
      end else if (a_load) begin
        tie     <= 1'b0;
        m_older <= 1'b1;
      end else if (m_load) begin
        tie     <= 1'b0;
        m_older <= 1'b0;
      end
      if (a_full && m_full && tie)
        rr_m <= !rr_m;
      RegWrite <= a_grant || m_grant;
      if (m_grant) begin
        Write_Reg <= m_reg_q;
        Write_Bus <= m_data_q;
      end else if (a_grant) begin
        Write_Reg <= a_reg_q;
        Write_Bus <= a_data_q;
      end
    end
  end

`ifdef WB_BUSY_VEC_EN
  always_comb begin
    Busy = '0;
    if (a_full) Busy = Busy | (16'd1 << a_reg_q);
    if (m_full) Busy = Busy | (16'd1 << m_reg_q);
  end
`else
  assign Busy = 16'h0000;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, single write, ties, age priority, streaming, mid-op reset.
module tb_reg_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        A_Valid, M_Valid;
  logic [3:0]  A_Reg, M_Reg;
  logic [15:0] A_Data, M_Data;
  logic        A_Ready, M_Ready;
  logic        RegWrite;
  logic [3:0]  Write_Reg;
  logic [15:0] Write_Bus;
  logic [15:0] Busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] wlog[$];
  logic [15:0] rf[16];

  reg_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .A_Valid(A_Valid), .A_Reg(A_Reg), .A_Data(A_Data), .A_Ready(A_Ready),
    .M_Valid(M_Valid), .M_Reg(M_Reg), .M_Data(M_Data), .M_Ready(M_Ready),
    .RegWrite(RegWrite), .Write_Reg(Write_Reg), .Write_Bus(Write_Bus), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Register-file model and write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && RegWrite === 1'b1) begin
      wlog.push_back(Write_Bus);
      rf[Write_Reg] = Write_Bus;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    A_Valid = 1'b0;
    M_Valid = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [3:0] r, input logic [15:0] d);
    checks++;
    if (RegWrite !== 1'b1 || Write_Reg !== r || Write_Bus !== d) begin
      errors++;
      $display("FAIL %s: got we=%b reg=%0d data=%h, want we=1 reg=%0d data=%h",
               name, RegWrite, Write_Reg, Write_Bus, r, d);
    end
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL %s: got RegWrite=%b, want 0", name, RegWrite);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A_Valid = 1'b1; A_Reg = 4'd1; A_Data = 16'h1234;
    M_Valid = 1'b1; M_Reg = 4'd2; M_Data = 16'h5678;
    cyc(); cyc();
    checks++;
    if (RegWrite !== 1'b0 || Write_Reg !== 4'd0 || Write_Bus !== 16'h0) begin
      errors++;
      $display("FAIL reset_out: got we=%b reg=%0d data=%h, want 0/0/0000", RegWrite, Write_Reg, Write_Bus);
    end
    checks++;
    if (Busy !== 16'h0) begin
      errors++;
      $display("FAIL reset_busy: got %h, want 0000", Busy);
    end
    idle();
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    checks++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d writes, want 0", wlog.size());
    end
  endtask

  task automatic test_single();
    A_Valid = 1'b1; A_Reg = 4'd3; A_Data = 16'hBEEF;
    checks++;
    if (A_Ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b, want 1", A_Ready);
    end
    cyc();
    idle();
    expect_idle("single_lat");
    cyc();
    expect_write("single_wr", 4'd3, 16'hBEEF);
    cyc();
    expect_idle("single_done");
    checks++;
    if (Write_Bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_hold: got %h, want beef", Write_Bus);
    end
  endtask

  task automatic tie_once(input string name, input logic [15:0] da, input logic [15:0] dm,
                          input logic [15:0] first, input logic [15:0] second);
    A_Valid = 1'b1; A_Reg = 4'd5; A_Data = da;
    M_Valid = 1'b1; M_Reg = 4'd5; M_Data = dm;
    checks++;
    if (A_Ready !== 1'b1 || M_Ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got A=%b M=%b, want 1/1", name, A_Ready, M_Ready);
    end
    cyc();
    idle();
    expect_idle({name, "_lat"});
    cyc();
    expect_write({name, "_first"}, 4'd5, first);
    cyc();
    expect_write({name, "_second"}, 4'd5, second);
    cyc();
    expect_idle({name, "_done"});
    checks++;
    if (rf[5] !== second) begin
      errors++;
      $display("FAIL %s_final: got r5=%h, want %h", name, rf[5], second);
    end
  endtask

  task automatic test_tie();
    tie_once("tie1", 16'h1111, 16'h2222, 16'h1111, 16'h2222);
    tie_once("tie2", 16'h3333, 16'h4444, 16'h4444, 16'h3333);
  endtask

  task automatic test_age();
    M_Valid = 1'b1; M_Reg = 4'd7; M_Data = 16'h0700;
    cyc();
    M_Valid = 1'b0;
    A_Valid = 1'b1; A_Reg = 4'd8; A_Data = 16'h0800;
    cyc();
    idle();
    expect_write("age_m", 4'd7, 16'h0700);
    cyc();
    expect_write("age_a", 4'd8, 16'h0800);
    cyc();
    expect_idle("age_done");
    // Pointer is A here; after the tie the pointer and age disagree on the third grant.
    A_Valid = 1'b1; A_Reg = 4'd1; A_Data = 16'hA001;
    M_Valid = 1'b1; M_Reg = 4'd1; M_Data = 16'hB001;
    cyc();
    M_Valid = 1'b0; A_Data = 16'hA002;
    checks++;
    if (A_Ready !== 1'b1 || M_Ready !== 1'b0) begin
      errors++;
      $display("FAIL age_ready1: got A=%b M=%b, want 1/0", A_Ready, M_Ready);
    end
    cyc();
    expect_write("age_w1", 4'd1, 16'hA001);
    A_Valid = 1'b0;
    M_Valid = 1'b1; M_Data = 16'hB002;
    checks++;
    if (A_Ready !== 1'b0 || M_Ready !== 1'b1) begin
      errors++;
      $display("FAIL age_ready2: got A=%b M=%b, want 0/1", A_Ready, M_Ready);
    end
    cyc();
    idle();
    expect_write("age_w2", 4'd1, 16'hB001);
    cyc();
    expect_write("age_w3", 4'd1, 16'hA002);
    cyc();
    expect_write("age_w4", 4'd1, 16'hB002);
    cyc();
    expect_idle("age_done2");
  endtask

  task automatic test_back_to_back();
    A_Valid = 1'b1; A_Reg = 4'd2;
    for (int i = 0; i < 8; i++) begin
      A_Data = 16'(i + 1);
      checks++;
      if (A_Ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b, want 1", i, A_Ready);
      end
      cyc();
      if (i >= 1) expect_write("b2b_wr", 4'd2, 16'(i));
    end
    idle();
    cyc();
    expect_write("b2b_last", 4'd2, 16'h0008);
    cyc();
    expect_idle("b2b_done");
  endtask

  task automatic test_reset_midop();
    wlog.delete();
    A_Valid = 1'b1; A_Reg = 4'd5; A_Data = 16'hAAAA;
    M_Valid = 1'b1; M_Reg = 4'd9; M_Data = 16'h9999;
    cyc();
    idle();
`ifdef WB_BUSY_VEC_EN
    checks++;
    if (Busy !== 16'h0220) begin
      errors++;
      $display("FAIL midop_busy: got %h, want 0220", Busy);
    end
`endif
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++;
    if (RegWrite !== 1'b0 || Write_Bus !== 16'h0 || Busy !== 16'h0) begin
      errors++;
      $display("FAIL midop_rst: got we=%b data=%h busy=%h, want 0/0000/0000", RegWrite, Write_Bus, Busy);
    end
    cyc(); cyc(); cyc(); cyc();
    checks++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL midop_drop: got %0d writes, want 0", wlog.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_single();
    test_tie();
    test_age();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU result (A) and memory load (M).
- Each requester has a valid/ready handshake and a one-entry holding buffer.
- Grants go oldest-first, with round-robin on ties.
- Drives registered RegWrite/Write_Reg/Write_Bus straight into the 16x16-bit register file.

Parameters:
- DATA_W, 16, width of write data
- ADDR_W, 4, width of register address (16 registers; 14 = Data_Segment, 15 = Stack_Pointer)

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- A_Valid  in  1  ALU writeback request
- A_Reg  in  ADDR_W  ALU destination register
- A_Data  in  DATA_W  ALU writeback data
- A_Ready  out  1  ALU request accepted this cycle when A_Valid & A_Ready
- M_Valid  in  1  memory-load writeback request
- M_Reg  in  ADDR_W  load destination register
- M_Data  in  DATA_W  load data
- M_Ready  out  1  load request accepted when M_Valid & M_Ready
- RegWrite  out  1  register file write enable (registered)
- Write_Reg  out  ADDR_W  register file write address (registered)
- Write_Bus  out  DATA_W  register file write data (registered)
- Busy  out  16  per-register pending-write vector (only with WB_BUSY_VEC_EN; tied 0 otherwise)

Behaviour:
- Reset (rst_n=0 at posedge):
  - RegWrite=0, Write_Reg=0, Write_Bus=0.
  - Both buffers empty; age bit cleared; round-robin pointer = A.
  - Pending requests are discarded.
  - Reset mid-operation drops buffered writes; nothing is written afterwards.
- Buffers:
  - Per requester: full flag, reg, data.
  - Accept when Valid & Ready; the buffer loads on that posedge.
- Ready:
  - X_Ready = !X_full | X_grant, where X_grant is this cycle's combinational grant.
  - A request can therefore be accepted in the same cycle its buffer drains; sustained throughput is 1 write/cycle per requester when uncontested.
- Ready is combinational from internal state only, never from Valid.
- Grant (combinational, evaluated each cycle from buffer state):
  - Neither full: no grant.
  - One full: grant it.
  - Both full: grant the older buffer per the age bit.
  - Both full and accepted on the same edge: grant per the round-robin pointer, then flip the pointer.
- Age bit:
  - Set to identify the older buffer when one is accepted while the other is already full.
  - Updated when a buffer drains and refills.
- Output stage:
  - On a grant, the next posedge loads RegWrite=1, Write_Reg and Write_Bus from the granted buffer, and clears (or refills) its full flag.
  - With no grant, RegWrite=0 next cycle; Write_Reg/Write_Bus hold their last values.
- Latency: request accepted at edge N -> RegWrite high in the cycle after edge N+1 at the earliest; one extra cycle per loss in arbitration.
- Ordering:
  - Writes from one requester complete in acceptance order.
  - Across requesters, acceptance order is preserved except for simultaneous acceptance. For same-register simultaneous acceptance, the round-robin loser's value is the final value.
- Simultaneous accept and drain on the same buffer: drain uses the old contents, load stores the new ones; the full flag stays 1.
- Max wait for a full buffer: 1 cycle (the other buffer cannot be granted twice consecutively while this one is full and older or tied).

Optional Feature:
- Macro: WB_BUSY_VEC_EN.
- Defined:
  - Busy[r] = 1 when any full buffer targets register r.
  - Computed from registered buffer state; cleared the cycle after the write is issued.
  - Busy is 0 on reset.
  - Decode stages use it to stall reads of in-flight registers.
- Undefined: Busy is driven constant 16'h0000 and no decode logic is synthesized.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with A_Valid=M_Valid=1 -> RegWrite=0, Write_Reg=0, Write_Bus=0, no writes after release until a new accept.
- Single ALU write: A_Valid=1, A_Reg=3, A_Data=16'hBEEF for 1 cycle -> A_Ready=1; RegWrite=1, Write_Reg=3, Write_Bus=16'hBEEF exactly one cycle later, then RegWrite=0.
- Simultaneous tie: A (reg 5, 16'h1111) and M (reg 5, 16'h2222) accepted on the same edge from reset -> A written first (pointer=A), M on the next cycle; reg 5 ends 16'h2222. Repeat the tie -> M first, A second.
- Age priority: M accepted (reg 7, 16'h0700); A accepted next cycle while M still full -> M written before A regardless of pointer.
- Back-to-back streaming: A_Valid held for 8 cycles with M idle, data 16'h0001..16'h0008 to reg 2 -> A_Ready stays 1 throughout; RegWrite high 8 consecutive cycles with data in order.
- Reset mid-operation: both buffers full, rst_n=0 for one edge -> neither buffered value ever appears on Write_Bus. With WB_BUSY_VEC_EN defined: Busy[5] and Busy[9] high while pending, Busy=0 after reset.
